// File: rtl/aes128_iter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes128_iter_ctrl_pkg
// Shared definitions for the iterative AES-128 encryption controller:
//   - fsm_state_t     : controller states (IDLE=0, RUN=1, DONE=2)
//   - NR              : number of AES-128 rounds
//   - rcon()          : round constant for rounds 1..10 (0 elsewhere)
//   - sbox()          : AES S-box (GF(2^8) inverse followed by the affine map)
//   - sub_bytes(), shift_rows(), mix_columns() : combinational round stages
// State byte k lives at bits [127-8k -: 8]; byte r+4c is s[r][c] (column-major).
// -----------------------------------------------------------------------------
package aes128_iter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    localparam logic [3:0] NR = 4'd10;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Inverse is x^254 built by square-and-multiply; 0 maps to 0 naturally.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        return r;
    endfunction

    // Row r rotates left by r columns: out s[r][c] = in s[r][(c+r) mod 4].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127-32*col -: 8];
            a1 = s[119-32*col -: 8];
            a2 = s[111-32*col -: 8];
            a3 = s[103-32*col -: 8];
            r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_iter_ctrl_key_step.sv
// -----------------------------------------------------------------------------
// aes128_iter_ctrl_key_step
// One step of the AES-128 key schedule (combinational).
//   rk   [127:0] : current round key {w0,w1,w2,w3}
//   rcon [7:0]   : round constant for the key being produced
//   nk   [127:0] : next round key
// t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', ...
// -----------------------------------------------------------------------------
module aes128_iter_ctrl_key_step
    import aes128_iter_ctrl_pkg::sbox;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] nk
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk;
    assign rot_w3           = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign sub_w3[8*g +: 8] = sbox(rot_w3[8*g +: 8]);
    end

    assign t  = sub_w3 ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_iter_ctrl.sv
// -----------------------------------------------------------------------------
// aes128_iter_ctrl
// Iterative AES-128 encryption: one round per clock, round keys on the fly.
//   clk, rst_n          : rising-edge clock, async active-low reset
//   in_valid/in_ready   : job handshake, in_pt (plaintext) and in_key (key)
//   out_valid/out_ready : result handshake, out_ct (ciphertext)
//   busy                : a job is in RUN or DONE
// Job accepted at E0, rounds at E1..E10, out_valid from E10 until out_ready.
// out_ct always shows the working state; it is the ciphertext only in DONE.
// -----------------------------------------------------------------------------
module aes128_iter_ctrl
    import aes128_iter_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct,
    output logic         busy
);

    fsm_state_t   fsm_q, fsm_d;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [3:0]   round;

    logic         load;
    logic         step;
    logic         round_ok;
    logic         last_round;
    logic [7:0]   rcon_cur;
    logic [127:0] nk;
    logic [127:0] sb_out;
    logic [127:0] sr_out;
    logic [127:0] mc_out;
    logic [127:0] round_out;

    // Round datapath; the last round skips MixColumns.
    assign round_ok   = (round >= 4'd1) && (round <= NR);
    assign last_round = (round == NR);
    assign rcon_cur   = rcon(round);
    assign sb_out     = sub_bytes(state_reg);
    assign sr_out     = shift_rows(sb_out);
    assign mc_out     = mix_columns(sr_out);
    assign round_out  = (last_round ? sr_out : mc_out) ^ nk;

    aes128_iter_ctrl_key_step u_key_step (
        .rk   (rk_reg),
        .rcon (rcon_cur),
        .nk   (nk)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= ST_IDLE;
        else        fsm_q <= fsm_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        fsm_d     = fsm_q;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load  = 1'b1;
                    fsm_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // A corrupted round counter abandons the job rather than
                // running past the key schedule.
                if (!round_ok) begin
                    fsm_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (last_round) fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            rk_reg    <= '0;
            round     <= 4'd0;
        end else if (load) begin
            state_reg <= in_pt ^ in_key;
            rk_reg    <= in_key;
            round     <= 4'd1;
        end else if (step) begin
            state_reg <= round_out;
            rk_reg    <= nk;
            round     <= round + 4'd1;
        end
    end

    assign out_ct = state_reg;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes128_iter_ctrl
// Self-checking bench for aes128_iter_ctrl. Expected ciphertexts come from a
// textbook AES-128 model: full key schedule expanded up front, byte-array
// state, S-box built by brute-force inverse search plus the bitwise affine map.
// -----------------------------------------------------------------------------
module tb_aes128_iter_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_pt;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_ct;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sbox_t [256];

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes128_iter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pt     (in_pt),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int prod;
        prod = 0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
        for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (32'h11b << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   coef [4];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   acc;
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) st[k] = sbox_t[st[k]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    tmp[row+4*col] = st[row+4*((col+row)%4)];
            for (int row = 0; row < 4; row++) begin
                for (int col = 0; col < 4; col++) begin
                    if (r < 10) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++)
                            acc = acc ^ gmul(coef[(j-row+4)%4], tmp[j+4*col]);
                        st[row+4*col] = acc;
                    end else begin
                        st[row+4*col] = tmp[row+4*col];
                    end
                end
            end
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present a job and return just after the acceptance edge E0.
    task automatic accept(input string tag, input logic [127:0] pt, input logic [127:0] key);
        @(negedge clk);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_pt    = pt;
        in_key   = key;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after E0 until out_valid, bounded.
    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(10));
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ov_drop"}, 128'(out_valid), 128'(0));
        check({tag, "_ir_back"}, 128'(in_ready), 128'(1));
        out_ready = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int hold);
        accept(tag, pt, key);
        wait_out(tag);
        check({tag, "_ct"}, out_ct, exp);
        repeat (hold) @(posedge clk);
        #1;
        check({tag, "_ct_held"}, out_ct, exp);
        handshake(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          cyc_q [$];
        logic [127:0] ct_q [$];
        logic [127:0] bp_exp;
        logic [127:0] pt, key;

        build_sbox();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pt     = '0;
        in_key    = '0;
        out_ready = 1'b0;

        #1;
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_out_ct",    out_ct,          128'(0));
        check("ref_app_b",     ref_aes(PT_B, KEY_B), CT_B);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 App. B with internal-state spot checks.
        accept("app_b", PT_B, KEY_B);
        check("app_b_state_e0", out_ct, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        check("app_b_busy",     128'(busy), 128'(1));
        check("app_b_run_ir",   128'(in_ready), 128'(0));
        wait_out("app_b");
        check("app_b_rk_e10", dut.rk_reg, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("app_b_ct", out_ct, CT_B);
        handshake("app_b");

        // FIPS-197 App. C.1.
        run_job("app_c1", PT_C, KEY_C, CT_C, 0);

        // Backpressure, with an ignored in_valid pulse during the hold.
        bp_exp = ref_aes(PT_B ^ 128'h1, KEY_B);
        accept("bp", PT_B ^ 128'h1, KEY_B);
        wait_out("bp");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_pt    = rand128();
                in_key   = rand128();
                in_valid = 1'b1;
            end
            if (i == 7) in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("bp_hold_ct", out_ct, bp_exp);
            check("bp_hold_ov", 128'(out_valid), 128'(1));
            check("bp_hold_ir", 128'(in_ready), 128'(0));
        end
        handshake("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp_not_queued_busy", 128'(busy), 128'(0));
        check("bp_not_queued_ov",   128'(out_valid), 128'(0));

        // Back-to-back: in_valid held high, out_ready high.
        @(negedge clk);
        in_pt     = PT_B;
        in_key    = KEY_B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_pt  = PT_C;
        in_key = KEY_C;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cyc_q.push_back(c);
                ct_q.push_back(out_ct);
            end
            if (c == 11) check("b2b_idle_e11", 128'(in_ready), 128'(1));
            if (c == 12) begin
                check("b2b_accept_e12", 128'(busy), 128'(1));
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        check("b2b_count", 128'(cyc_q.size()), 128'(2));
        if (cyc_q.size() == 2) begin
            check("b2b_cyc0", 128'(cyc_q[0]), 128'(10));
            check("b2b_ct0",  ct_q[0], CT_B);
            check("b2b_cyc1", 128'(cyc_q[1]), 128'(22));
            check("b2b_ct1",  ct_q[1], CT_C);
        end

        // Randomized jobs with random backpressure.
        for (int n = 0; n < 8; n++) begin
            pt  = rand128();
            key = rand128();
            run_job("rand", pt, key, ref_aes(pt, key), int'($urandom_range(0, 4)));
        end

        // Asynchronous reset in round 5.
        accept("rst_mid", rand128(), rand128());
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ov",    128'(out_valid), 128'(0));
        check("rst_mid_ir",    128'(in_ready),  128'(1));
        check("rst_mid_busy",  128'(busy),      128'(0));
        check("rst_mid_round", 128'(dut.round), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_no_emit", 128'(out_valid), 128'(0));
        run_job("post_rst_c1", PT_C, KEY_C, CT_C, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes128_iter_ctrl.md
# aes128_iter_ctrl

Iterative AES-128 encryption controller: accepts a plaintext/key pair over a valid/ready handshake, then executes one AES round per clock using the codebase's combinational SubBytes, ShiftRows and MixColumns modules. Round keys are expanded on the fly, one per cycle. The block sits between the host-side request interface and the shared round datapath. It owns the round counter, Rcon sequencing, the MixColumns bypass in the final round, and the result handshake.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- in_valid  input  1  plaintext and key present.
- in_ready  output  1  block can accept a new job.
- in_pt  input  128  plaintext.
- in_key  input  128  cipher key.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_ct  output  128  ciphertext.
- busy  output  1  job in progress (RUN or DONE).

## Operation
- Byte order: bits [127:120] = input byte 0 = s[0][0], column-major (FIPS-197 order). This is the same order the ShiftRows module uses.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid at a clock edge:
    - state_reg <= in_pt ^ in_key
    - rk_reg <= in_key
    - round <= 1
    - go to RUN.
  - RUN, each cycle:
    - nk = key_step(rk_reg, rcon(round)).
    - round < 10: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ nk.
    - round = 10: state_reg <= ShiftRows(SubBytes(state_reg)) ^ nk. MixColumns is bypassed.
    - rk_reg <= nk; round <= round+1.
    - After the round-10 edge, go to DONE.
  - DONE: out_valid=1 and out_ct=state_reg, held stable. On out_ready go to IDLE. out_valid deasserts the same edge.
- in_ready=0 in RUN and DONE. in_valid there is ignored; the job is not queued.
- Rcon by round 1..10: 01,02,04,08,10,20,40,80,1B,36. The round counter is 4 bits. Values 0 and 11..15 are unreachable; if one occurs, return to IDLE.
- key_step(w): t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- out_ct is valid only while out_valid=1. In other states it shows the working state.

## Timing
- Reset (async, rst_n=0): fsm=IDLE, round=0, state_reg=0, rk_reg=0, out_valid=0, busy=0, in_ready=1. Outputs are combinational from the FSM and reach these values without waiting for a clock.
- Acceptance edge E0. Rounds complete at edges E1..E10. out_valid is high from E10.
- Latency: 10 cycles from acceptance to out_valid.
- If out_ready is already high at E10, the handshake completes at E11. Minimum job spacing is therefore 12 cycles: the next in_valid is accepted at E12 at the earliest.
- Backpressure: out_valid/out_ct hold indefinitely until out_ready.
- Reset mid-job (RUN or DONE): the job is aborted, nothing is emitted, and the block returns to IDLE.
- out_ready while not in DONE is ignored.

## Structure
- Shared header aes_defs.vh:
  - FSM encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - NR=10.
  - rcon(round) function.
- Sub-module aes_key_step (combinational): inputs rk[127:0] and rcon[7:0], output nk[127:0]. It uses 4 instances of the existing S-box for SubWord.
- The top level instantiates SubBytes, ShiftRows and MixColumns once each, plus the final-round mux, the FSM and the registers.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_ct 3925841d02dc09fbdc118597196a0b32. out_valid rises exactly 10 cycles after acceptance.
- Same vector, internal check: state_reg after E0 = 193de3bea0f4e22b9ac68d2ae9f84808. rk_reg after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure and overlap:
  - Hold out_ready=0 for 20 cycles -> out_ct stable, in_ready=0.
  - Pulse in_valid with other data during the hold -> ignored.
  - Raise out_ready -> out_valid drops next edge; in_ready=1.
- Back-to-back: in_valid held high with both vectors, out_ready=1 -> results in order, accepted 12 cycles apart.
- Reset mid-job: assert rst_n=0 asynchronously at round 5 -> out_valid=0 and in_ready=1 immediately, no clock needed. A new App. C.1 job then produces the correct ciphertext.
